// File: rtl/rdchk_pkg.sv
// Shared constants and state type for the read-side pattern checker.
// The write-pattern sequencer imports the same constants, so the addresses
// it fills and the addresses read back here cannot drift apart.
package rdchk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } rdchk_state_e;

  localparam int unsigned DEF_NUM_WORDS = 9;
  localparam logic [30:0] DEF_BASE_ADDR = 31'h000_1000;
  localparam logic [30:0] DEF_STRIDE    = 31'h4;
  localparam int unsigned DEF_TIMEOUT   = 255;

  // Per-word wait timer width; covers TIMEOUT up to 255.
  localparam int unsigned TMO_W = 8;
  // Word index width; covers NUM_WORDS up to 15.
  localparam int unsigned IDX_W = 4;

endpackage

// File: rtl/rdchk_addr_gen.sv
// Read address generator: tracks the word index, produces
// BASE_ADDR + idx*STRIDE incrementally (31-bit wrap), flags the last word.
module rdchk_addr_gen
  import rdchk_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [30:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [30:0] STRIDE    = DEF_STRIDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_advance,
  output logic [30:0] o_addr,
  output logic        o_last
);

  logic [IDX_W-1:0] r_idx;
  logic [30:0]      r_addr;

  // Index and running address; the address is accumulated rather than multiplied.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_idx  <= '0;
      r_addr <= BASE_ADDR;
    end else if (i_advance) begin
      r_idx  <= r_idx + 1'b1;
      r_addr <= r_addr + STRIDE;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_idx == IDX_W'(NUM_WORDS - 1));

endmodule

// File: rtl/read_data_check.sv
// Read-back checker for the MIG write-pattern test path: reads NUM_WORDS
// single words one at a time and expects data == address.
// Optional build macro READ_DATA_CHECK_STOP_ON_ERR_EN: end the run at the
// first mismatch or timeout instead of reading every word.
module read_data_check
  import rdchk_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [30:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [30:0] STRIDE    = DEF_STRIDE,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mc_rd_rdy,
  output logic        rd_en,
  output logic [30:0] rd_addr,
  input  logic        rd_data_valid,
  input  logic [30:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [30:0] err_addr,
  output logic        timeout
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  rdchk_state_e     r_state, w_next;
  logic [TMO_W-1:0] r_timer;
  logic [30:0]      r_data;
  logic             r_tmo_word;
  logic             r_pass;
  logic [7:0]       r_err_cnt;
  logic [30:0]      r_err_addr;
  logic             r_timeout;

  logic        w_clear;
  logic        w_advance;
  logic [30:0] w_addr;
  logic        w_last;
  logic        w_mismatch;
  logic        w_tmo_hit;
  logic        w_err_evt;
  logic        w_stop;

  rdchk_addr_gen #(
    .NUM_WORDS (NUM_WORDS),
    .BASE_ADDR (BASE_ADDR),
    .STRIDE    (STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  // A timed-out word skips the data compare; its error is counted in WAIT.
  assign w_mismatch = (r_state == S_CHECK) && !r_tmo_word && (r_data != w_addr);
  assign w_tmo_hit  = (r_state == S_WAIT) && !rd_data_valid && (r_timer == TMO_LAST);
  assign w_err_evt  = w_mismatch || w_tmo_hit;

`ifdef READ_DATA_CHECK_STOP_ON_ERR_EN
  assign w_stop = w_mismatch || r_tmo_word;
`else
  assign w_stop = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode plus address generator control.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mc_rd_rdy) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (rd_data_valid || w_tmo_hit) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_last || w_stop) begin
          w_next = S_DONE;
        end else begin
          w_advance = 1'b1;
          w_next    = S_ISSUE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Per-word timer, data capture, and run result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer    <= '0;
      r_data     <= '0;
      r_tmo_word <= 1'b0;
      r_pass     <= 1'b0;
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
            r_timeout  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_timer    <= '0;
          r_tmo_word <= 1'b0;
        end
        S_WAIT: begin
          if (rd_data_valid) begin
            r_data <= rd_data;
          end else begin
            r_timer <= r_timer + 1'b1;
            if (w_tmo_hit) begin
              r_tmo_word <= 1'b1;
              r_timeout  <= 1'b1;
            end
          end
        end
        S_DONE:  r_pass <= (r_err_cnt == '0);
        default: ;
      endcase
      if (w_err_evt) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0) r_err_addr <= w_addr;
      end
    end
  end

  assign rd_en    = (r_state == S_ISSUE);
  assign rd_addr  = w_addr;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign err_addr = r_err_addr;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_read_data_check.sv
// Directed bench for read_data_check: clean run, corrupted word, ready
// back-pressure, read timeout with late data, and reset mid-run.
module tb_read_data_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mc_rd_rdy = 1'b0;
  logic        rd_en;
  logic [30:0] rd_addr;
  logic        rd_data_valid = 1'b0;
  logic [30:0] rd_data = '0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [30:0] err_addr;
  logic        timeout;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  read_data_check dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mc_rd_rdy     (mc_rd_rdy),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .err_addr      (err_addr),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd_en"},    {31'd0, rd_en},   32'd0);
    check({tag, "_rd_addr"},  {1'b0, rd_addr},  32'h1000);
    check({tag, "_busy"},     {31'd0, busy},    32'd0);
    check({tag, "_done"},     {31'd0, done},    32'd0);
    check({tag, "_pass"},     {31'd0, pass},    32'd0);
    check({tag, "_err_cnt"},  {24'd0, err_cnt}, 32'd0);
    check({tag, "_err_addr"}, {1'b0, err_addr}, 32'd0);
    check({tag, "_timeout"},  {31'd0, timeout}, 32'd0);
  endtask

  // Entered in the first ISSUE cycle of a word; leaves one cycle after CHECK.
  task automatic serve(input logic [30:0] a, input int unsigned rdy_low,
                       input logic [30:0] d, input logic [7:0] exp_err);
    mc_rd_rdy = (rdy_low == 0);
    check("issue_en",   {31'd0, rd_en}, 32'd1);
    check("issue_addr", {1'b0, rd_addr}, {1'b0, a});
    for (int unsigned k = 1; k < rdy_low; k++) begin
      tick();
      start = 1'b0;
      check("hold_en",   {31'd0, rd_en}, 32'd1);
      check("hold_addr", {1'b0, rd_addr}, {1'b0, a});
    end
    mc_rd_rdy = 1'b1;
    tick();
    start = 1'b0;
    mc_rd_rdy = 1'b0;
    check("wait_en", {31'd0, rd_en}, 32'd0);
    rd_data_valid = 1'b1;
    rd_data = d;
    tick();
    rd_data_valid = 1'b0;
    rd_data = '0;
    tick();
    check("word_err_cnt", {24'd0, err_cnt}, {24'd0, exp_err});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [30:0] a;

    // Reset state
    repeat (3) tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();

    // Run 1: clean, back-pressure on word 2, ignored start on word 4
    pulse_start();
    check("r1_busy", {31'd0, busy}, 32'd1);
    for (int unsigned i = 0; i < 9; i++) begin
      a = 31'h1000 + 31'(4 * i);
      if (i == 4) start = 1'b1;
      serve(a, (i == 2) ? 5 : 0, a, 8'd0);
    end
    check("r1_done",   {31'd0, done}, 32'd1);
    check("r1_busy_d", {31'd0, busy}, 32'd1);
    tick();
    check("r1_done_end", {31'd0, done}, 32'd0);
    check("r1_idle",     {31'd0, busy}, 32'd0);
    check("r1_pass",     {31'd0, pass}, 32'd1);
    check("r1_err_cnt",  {24'd0, err_cnt}, 32'd0);

    // Run 2: word at 0x1010 returns 0x1011
    pulse_start();
    check("r2_pass_clr", {31'd0, pass}, 32'd0);
`ifdef READ_DATA_CHECK_STOP_ON_ERR_EN
    for (int unsigned i = 0; i < 5; i++) begin
      a = 31'h1000 + 31'(4 * i);
      serve(a, 0, (i == 4) ? 31'h1011 : a, (i == 4) ? 8'd1 : 8'd0);
    end
    check("r2_stop_done", {31'd0, done}, 32'd1);
    check("r2_stop_en",   {31'd0, rd_en}, 32'd0);
    tick();
`else
    for (int unsigned i = 0; i < 9; i++) begin
      a = 31'h1000 + 31'(4 * i);
      serve(a, 0, (i == 4) ? 31'h1011 : a, (i >= 4) ? 8'd1 : 8'd0);
    end
    check("r2_done", {31'd0, done}, 32'd1);
    tick();
`endif
    check("r2_idle",     {31'd0, busy}, 32'd0);
    check("r2_pass",     {31'd0, pass}, 32'd0);
    check("r2_err_cnt",  {24'd0, err_cnt}, 32'd1);
    check("r2_err_addr", {1'b0, err_addr}, 32'h1010);
    check("r2_timeout",  {31'd0, timeout}, 32'd0);

    // Run 3: no data for 0x1018, late valid afterwards
    pulse_start();
    check("r3_err_clr",  {24'd0, err_cnt}, 32'd0);
    check("r3_addr_clr", {1'b0, err_addr}, 32'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      a = 31'h1000 + 31'(4 * i);
      serve(a, 0, a, 8'd0);
    end
    check("r3_w6_addr", {1'b0, rd_addr}, 32'h1018);
    mc_rd_rdy = 1'b1;
    tick();
    mc_rd_rdy = 1'b0;
    repeat (254) tick();
    check("r3_tmo_pre",  {31'd0, timeout}, 32'd0);
    check("r3_wait_en",  {31'd0, rd_en}, 32'd0);
    check("r3_err_pre",  {24'd0, err_cnt}, 32'd0);
    tick();
    check("r3_tmo",      {31'd0, timeout}, 32'd1);
    check("r3_tmo_cnt",  {24'd0, err_cnt}, 32'd1);
    check("r3_tmo_addr", {1'b0, err_addr}, 32'h1018);
    rd_data_valid = 1'b1;
    rd_data = 31'h5555;
    tick();
    rd_data_valid = 1'b0;
    rd_data = '0;
`ifdef READ_DATA_CHECK_STOP_ON_ERR_EN
    check("r3_stop_done", {31'd0, done}, 32'd1);
    tick();
`else
    for (int unsigned i = 7; i < 9; i++) begin
      a = 31'h1000 + 31'(4 * i);
      serve(a, 0, a, 8'd1);
    end
    check("r3_done", {31'd0, done}, 32'd1);
    tick();
`endif
    check("r3_pass",     {31'd0, pass}, 32'd0);
    check("r3_err_cnt",  {24'd0, err_cnt}, 32'd1);
    check("r3_err_addr", {1'b0, err_addr}, 32'h1018);
    check("r3_timeout",  {31'd0, timeout}, 32'd1);

    // Run 4: reset while waiting on word 2, then a fresh clean run
    pulse_start();
    serve(31'h1000, 0, 31'h1000, 8'd0);
    serve(31'h1004, 0, 31'h1004, 8'd0);
    mc_rd_rdy = 1'b1;
    tick();
    mc_rd_rdy = 1'b0;
    check("r4_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("r4_rst");
    rd_data_valid = 1'b1;
    rd_data = 31'h1008;
    tick();
    rd_data_valid = 1'b0;
    check("r4_stray_en", {31'd0, rd_en}, 32'd0);
    check("r4_stray_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    for (int unsigned i = 0; i < 9; i++) begin
      a = 31'h1000 + 31'(4 * i);
      serve(a, 0, a, 8'd0);
    end
    check("r4_done", {31'd0, done}, 32'd1);
    tick();
    check("r4_pass",    {31'd0, pass}, 32'd1);
    check("r4_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("r4_timeout", {31'd0, timeout}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
